// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter bit FWFT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       r_en,
  output logic [DATA_W-1:0]          dataout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] dout_q;
  logic              rd_ok;
  logic              wr_ok;
  logic [CW-1:0]     count_nxt;

  // Occupancy after one edge; the accept rules guarantee the result stays in 0..DEPTH.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + CW'(1);
    if (dec && !inc) res = cnt - CW'(1);
    return res;
  endfunction

  // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
  assign rd_ok     = r_en & ~empty;
  assign wr_ok     = w_en & (~full | rd_ok);
  assign count_nxt = next_count(count, wr_ok, rd_ok);

  // Storage: written only on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered flags, all derived from the next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      almost_full  <= (count_nxt >= AF_CNT);
    end
  end

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & ~wr_ok) | (overflow  & ~err_clr);
      underflow <= (r_en & ~rd_ok) | (underflow & ~err_clr);
    end
  end

  // Holds the last popped word: the read register in standard mode,
  // the stable head value shown while empty in FWFT mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rd_ptr];
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dataout = empty ? dout_q : mem[rd_ptr];
    end else begin : g_std
      assign dataout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard and FWFT instances driven in lockstep and
// compared against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              w_en, r_en, err_clr;
  logic [DATA_W-1:0] din;

  logic [DATA_W-1:0] dout0, dout1;
  logic              empty0, full0, ae0, af0, ovf0, udf0;
  logic              empty1, full1, ae1, af1, ovf1, udf1;
  logic [CW-1:0]     cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic              m_ovf, m_udf;
  logic [DATA_W-1:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dataout(dout0),
    .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0), .err_clr(err_clr));

  sync_fifo_flags #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dataout(dout1),
    .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Compare both instances against the model's view of the FIFO.
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count0"}, 32'(cnt0), 32'(n));
    chk({tag, ":count1"}, 32'(cnt1), 32'(n));
    chk({tag, ":empty"},  {30'd0, empty0, empty1}, {30'd0, n == 0, n == 0});
    chk({tag, ":full"},   {30'd0, full0, full1},   {30'd0, n == DEPTH, n == DEPTH});
    chk({tag, ":aempty"}, {30'd0, ae0, ae1},       {30'd0, n <= AE, n <= AE});
    chk({tag, ":afull"},  {30'd0, af0, af1},       {30'd0, n >= AF, n >= AF});
    chk({tag, ":ovf"},    {30'd0, ovf0, ovf1},     {30'd0, m_ovf, m_ovf});
    chk({tag, ":udf"},    {30'd0, udf0, udf1},     {30'd0, m_udf, m_udf});
    chk({tag, ":dout_std"}, 32'(dout0), 32'(m_dout));
    if (n > 0) chk({tag, ":dout_fwft_head"}, 32'(dout1), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model on pre-edge state, then check after the edge.
  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r,
                       input logic clr, input string tag);
    logic rd, wr;
    w_en = w; din = d; r_en = r; err_clr = clr;
    rd = r && (q.size() > 0);
    wr = w && ((q.size() < DEPTH) || rd);
    m_ovf = (w && !wr) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = (r && !rd) ? 1'b1 : (clr ? 1'b0 : m_udf);
    if (rd) m_dout = q.pop_front();
    if (wr) q.push_back(d);
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; din = '0;
    model_reset();

    // 1. Reset held for three cycles, then released
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_dout_fwft", 32'(dout1), 32'h0);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "post_reset");

    // 2. Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      chk("fill_af_edge", 32'(af0), 32'(i + 1 >= 12));
    end
    chk("fill_full", 32'(full0), 32'h1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, "overflow_write");
    chk("ovf_set", 32'(ovf0), 32'h1);

    // 3. Drain in order, one rejected read, then clear the errors
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      chk("drain_data", 32'(dout0), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "underflow_read");
    chk("udf_dout_hold", 32'(dout0), 32'h0F);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "err_clr");

    // 4. Simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "full_rw");
    chk("full_rw_oldest", 32'(dout0), 32'h10);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
    chk("last_is_55", 32'(dout0), 32'h55);

    // 5. Simultaneous read/write while empty: read rejected, write accepted
    cycle(1'b1, 8'h33, 1'b1, 1'b0, "empty_rw");
    chk("empty_rw_udf", 32'(udf0), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "read_33");
    chk("read_33_data", 32'(dout0), 32'h33);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "err_clr2");

    // 6. Random interleaved traffic; pointers wrap several times
    for (int i = 0; i < 160; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(w, 8'($urandom), r, c, "random");
    end

    // Reset mid-traffic discards everything; assertion is asynchronous
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, 8'h7E, 1'b0, 1'b0, "after_rst_write");
    chk("after_rst_fwft_head", 32'(dout1), 32'h7E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
